idu_fetch_rx: RTL and testbench

Receive end of the fetch→decode valid/ready channel. Accepts {pc, inst} beats from the fetch unit and buffers them in a 2-entry skid buffer. Presents pc and inst separately to the decoder through a second valid/ready handshake. Sits at the IDU input and breaks the combinational ready path back to fetch. Supports a redirect flush from EXU.

---
 rtl/idu_fetch_rx_pkg.sv | 18 +
 rtl/idu_beat_reg.sv | 20 ++
 rtl/idu_fetch_rx.sv | 112 +++++++++++
 tb/tb_idu_fetch_rx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/idu_fetch_rx_pkg.sv
// Shared types and constants for the IDU fetch receive buffer.
// Beat layout is {pc, inst} with pc in the upper half.
package idu_fetch_rx_pkg;

  localparam int DATA_WIDTH = 32;

  localparam int PC_HI   = 2*DATA_WIDTH-1;
  localparam int PC_LO   = DATA_WIDTH;
  localparam int INST_HI = DATA_WIDTH-1;
  localparam int INST_LO = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } rx_state_e;

endpackage

// File: rtl/idu_beat_reg.sv
// Enable-loaded beat register with synchronous reset.
// Holds one {pc, inst} beat for the head or skid slot.
module idu_beat_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/idu_fetch_rx.sv
// Fetch-to-decode receive skid buffer (2 entries) with redirect flush.
// in_ready depends only on registered state, cutting the path from out_ready.
module idu_fetch_rx
  import idu_fetch_rx_pkg::*;
#(
  parameter int DATA_WIDTH = idu_fetch_rx_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0]   out_inst,
  output logic                    out_misaligned,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);

  localparam int BW = 2*DATA_WIDTH;

  rx_state_e       state_q;
  rx_state_e       state_d;
  logic            acc;
  logic            pop;
  logic            head_en;
  logic            skid_en;
  logic [BW-1:0]   head_d;
  logic [BW-1:0]   head_q;
  logic [BW-1:0]   skid_q;

  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY) & ~flush;
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign out_pc         = head_q[BW-1:DATA_WIDTH];
  assign out_inst       = head_q[DATA_WIDTH-1:0];
  assign out_misaligned = |head_q[DATA_WIDTH+1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Flush wins; acc and pop are already masked by it.
  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    skid_en = 1'b0;
    head_d  = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            head_en = 1'b1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            head_en = 1'b1;
          end else if (acc) begin
            state_d = FULL;
            skid_en = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_en = 1'b1;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  idu_beat_reg #(.WIDTH(BW)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .d   (head_d),
    .q   (head_q)
  );

  idu_beat_reg #(.WIDTH(BW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready)
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_idu_fetch_rx.sv
// Bench for idu_fetch_rx: directed scenarios plus random traffic.
// Reference is a bounded FIFO queue with a stall tally.
module tb_idu_fetch_rx;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic          out_misaligned;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] mq[$];
  int unsigned m_stall = 0;

  always #5 clk = ~clk;

  idu_fetch_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misaligned (out_misaligned),
    .stall_cnt      (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against model, clock, advance model.
  task automatic cyc(input logic r, input logic iv, input logic [63:0] d,
                     input logic fl, input logic orr, input bit chk = 1'b1);
    bit m_rdy, m_vld, m_acc, m_pop;
    rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = orr;
    #1;
    m_rdy = (mq.size() < 2) && !r;
    m_vld = (mq.size() > 0) && !fl;
    m_acc = iv && m_rdy && !fl;
    m_pop = m_vld && orr;
    if (chk) begin
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("out_valid", 64'(out_valid), 64'(m_vld));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (mq.size() > 0) begin
        check("out_pc", 64'(out_pc), 64'(mq[0][63:32]));
        check("out_inst", 64'(out_inst), 64'(mq[0][31:0]));
        check("out_misaligned", 64'(out_misaligned),
              64'(mq[0][33:32] != 2'b00));
      end
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_stall = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (m_vld && !orr) m_stall++;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] bt(input logic [31:0] pc);
    return {pc, pc ^ 32'h0000_0413};
  endfunction

  initial begin
    logic r, fl, iv, orr;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    cyc(1, 0, 64'h0, 0, 0, 1'b0);
    cyc(1, 0, 64'h0, 0, 0);
    check("rst_out_pc", 64'(out_pc), 64'h0);
    check("rst_out_mis", 64'(out_misaligned), 64'h0);

    // First beat after reset release
    cyc(0, 1, {32'h8000_0000, 32'h0000_0413}, 0, 1);
    check("first_valid", 64'(out_valid), 64'h1);
    check("first_pc", 64'(out_pc), 64'h8000_0000);
    check("first_inst", 64'(out_inst), 64'h0000_0413);
    cyc(0, 0, 64'h0, 0, 1);

    // Streaming, one beat per cycle
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, bt(32'h8000_0000 + 32'(4*k)), 0, 1);
      check("stream_pc", 64'(out_pc), 64'(32'h8000_0000 + 32'(4*k)));
    end
    cyc(0, 0, 64'h0, 0, 1);
    check("stream_stall", 64'(stall_cnt), 64'h0);

    // Backpressure fills the skid, third beat held by fetch
    cyc(0, 1, bt(32'h8000_0000), 0, 0);
    cyc(0, 1, bt(32'h8000_0004), 0, 0);
    check("full_in_ready", 64'(in_ready), 64'h0);
    cyc(0, 1, bt(32'h8000_0008), 0, 0);
    check("stall_two", 64'(stall_cnt), 64'h2);
    check("stall_head", 64'(out_pc), 64'h8000_0000);
    cyc(0, 1, bt(32'h8000_0008), 0, 1);
    check("drain_pc1", 64'(out_pc), 64'h8000_0004);
    cyc(0, 1, bt(32'h8000_0008), 0, 1);
    check("drain_pc2", 64'(out_pc), 64'h8000_0008);
    cyc(0, 0, 64'h0, 0, 1);

    // Flush while FULL drops everything including incoming beat
    cyc(0, 1, bt(32'h8000_0010), 0, 0);
    cyc(0, 1, bt(32'h8000_0014), 0, 0);
    cyc(0, 1, bt(32'h8000_0018), 1, 0);
    check("flush_empty", 64'(out_valid), 64'h0);
    cyc(0, 1, bt(32'h8000_0100), 0, 1);
    check("post_flush_pc", 64'(out_pc), 64'h8000_0100);
    cyc(0, 0, 64'h0, 0, 1);

    // Misaligned pc is flagged but still delivered
    cyc(0, 1, bt(32'h8000_0002), 0, 0);
    check("mis_set", 64'(out_misaligned), 64'h1);
    cyc(0, 1, bt(32'h8000_0004), 0, 1);
    check("mis_clr", 64'(out_misaligned), 64'h0);
    check("mis_next_pc", 64'(out_pc), 64'h8000_0004);
    cyc(0, 0, 64'h0, 0, 1);

    // Reset while FULL
    cyc(0, 1, bt(32'h8000_0200), 0, 0);
    cyc(0, 1, bt(32'h8000_0204), 0, 0);
    cyc(1, 0, 64'h0, 0, 0);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_pc", 64'(out_pc), 64'h0);
    check("mid_rst_stall", 64'(stall_cnt), 64'h0);
    check("mid_rst_ready", 64'(in_ready), 64'h0);
    cyc(1, 0, 64'h0, 0, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      cyc(r, iv, {$urandom(), $urandom()}, fl, orr);
    end
    cyc(0, 0, 64'h0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
